// File: rtl/object_motion.sv
// Tick-driven motion engine for one on-screen object: gravity, slice, exit.
// OBJECT_MOTION_WALL_BOUNCE_EN: x edges clamp and reflect instead of ending flight.
module object_motion #(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int V_W      = 8,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           launch,
    input  logic [X_W-1:0] launch_x,
    input  logic [Y_W-1:0] launch_y,
    input  logic [V_W-1:0] launch_vx,
    input  logic [V_W-1:0] launch_vy,
    input  logic           slice,
    output logic [X_W-1:0] posx,
    output logic [Y_W-1:0] posy,
    output logic [V_W-1:0] vy_o,
    output logic           active,
    output logic           sliced_o,
    output logic           done
);
    localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam logic signed [W-1:0] XMAX = W'(SCREEN_W - 1);
    localparam logic signed [W-1:0] YLIM = W'(SCREEN_H);
    localparam logic signed [V_W:0] GV   = (V_W+1)'(GRAVITY);
    localparam logic signed [V_W:0] VM   = (V_W+1)'(V_MAX);

    typedef enum logic [1:0] {IDLE, FLY, EXIT} state_t;

    state_t                state;
    logic [1:0]            samp;
    logic [V_W-1:0]        vx;
    logic                  upd;
    logic [V_W-1:0]        vx_eff;
    logic signed [W-1:0]   nx;
    logic signed [W-1:0]   ny;
    logic                  x_lo;
    logic                  x_hi;
    logic                  x_exit;
    logic                  y_top;
    logic                  y_exit;
    logic [V_W-1:0]        vy_base;
    logic signed [V_W:0]   vg;
    logic [V_W-1:0]        vy_next;

    assign upd = (samp == 2'b01);

    // A same-cycle slice zeroes vx before the position step uses it.
    always_comb begin
        vx_eff  = slice ? '0 : vx;
        nx      = $signed({{(W-X_W){1'b0}}, posx})
                + $signed({{(W-V_W){vx_eff[V_W-1]}}, vx_eff});
        ny      = $signed({{(W-Y_W){1'b0}}, posy})
                + $signed({{(W-V_W){vy_o[V_W-1]}}, vy_o});
        x_lo    = nx[W-1];
        x_hi    = nx > XMAX;
`ifdef OBJECT_MOTION_WALL_BOUNCE_EN
        x_exit  = 1'b0;
`else
        x_exit  = x_lo | x_hi;
`endif
        y_top   = ny[W-1];
        y_exit  = (ny >= YLIM) && !vy_o[V_W-1] && (vy_o != '0);
        vy_base = y_top ? '0 : vy_o;
        vg      = $signed({vy_base[V_W-1], vy_base}) + GV;
        vy_next = (vg > VM) ? VM[V_W-1:0] : vg[V_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            samp     <= 2'b00;
            vx       <= '0;
            posx     <= '0;
            posy     <= '0;
            vy_o     <= '0;
            active   <= 1'b0;
            sliced_o <= 1'b0;
            done     <= 1'b0;
        end else begin
            samp <= {samp[0], tick};
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (launch) begin
                        posx     <= launch_x;
                        posy     <= launch_y;
                        vx       <= launch_vx;
                        vy_o     <= launch_vy;
                        sliced_o <= 1'b0;
                        active   <= 1'b1;
                        state    <= FLY;
                    end
                end
                FLY: begin
                    if (slice) begin
                        vx       <= '0;
                        sliced_o <= 1'b1;
                    end
                    if (upd) begin
                        if (x_exit) begin
                            state  <= EXIT;
                            active <= 1'b0;
                            done   <= 1'b1;
                        end else begin
`ifdef OBJECT_MOTION_WALL_BOUNCE_EN
                            if (x_lo) begin
                                posx <= '0;
                                vx   <= -vx_eff;
                            end else if (x_hi) begin
                                posx <= XMAX[X_W-1:0];
                                vx   <= -vx_eff;
                            end else begin
                                posx <= nx[X_W-1:0];
                            end
`else
                            posx <= nx[X_W-1:0];
`endif
                            vy_o <= vy_next;
                            if (y_exit) begin
                                state  <= EXIT;
                                active <= 1'b0;
                                done   <= 1'b1;
                            end else begin
                                posy <= y_top ? '0 : ny[Y_W-1:0];
                            end
                        end
                    end
                end
                EXIT: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done   <= 1'b0;
                    active <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/object_motion.md
Name: object_motion

Overview:
- Parametrised, tick-driven motion engine for one on-screen object (fruit/bomb) in the game.
- Supersedes the older fixed-step mover: signed velocities, per-tick gravity on vy, launch/slice handshakes, wall bounce, and off-screen exit detection.
- Sits between the spawner (launch, slice) and the renderer, which reads posx/posy/active.
- The frame tick source drives all motion updates.

Parameters:
- X_W, 10, width of posx.
- Y_W, 9, width of posy.
- V_W, 8, width of signed velocities.
- SCREEN_W, 640, visible x range is 0..SCREEN_W-1.
- SCREEN_H, 480, visible y range is 0..SCREEN_H-1.
- GRAVITY, 1, added to vy every update tick.
- V_MAX, 15, positive saturation limit for vy.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  level frame tick; a rising edge triggers one update.
- launch  in  1  single-cycle start request.
- launch_x  in  X_W  start x.
- launch_y  in  Y_W  start y.
- launch_vx  in  V_W  signed start vx.
- launch_vy  in  V_W  signed start vy (negative means upward).
- slice  in  1  single-cycle hit; object stops moving horizontally.
- posx  out  X_W  current x.
- posy  out  Y_W  current y.
- vy_o  out  V_W  current signed vy.
- active  out  1  high while in FLY.
- sliced_o  out  1  high once sliced, until the next launch.
- done  out  1  single-cycle pulse when the object leaves the screen.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - posx = 0, posy = 0, vy_o = 0.
  - active = 0, sliced_o = 0, done = 0.
  - Internal vx = 0, tick sampler = 00, state = IDLE.
- Reset mid-flight aborts immediately to IDLE; no done pulse is emitted.
- Tick detection: a 2-bit sampler shifts in tick every clk. An update fires when sampler == 01. Positions change on the second clk edge after tick is first sampled high. Tick held high gives exactly one update.
- States:
  - IDLE: launch=1 loads posx/posy/vx/vy from the launch inputs, clears sliced_o, and moves to FLY on the next edge. Ticks are ignored.
  - FLY: active = 1. launch is ignored. Each update does the following, in order:
    - Compute nx = posx + vx and ny = posy + vy, signed, width max(X_W,Y_W)+2.
    - X edges: if nx < 0, posx = 0 and vx = -vx. If nx > SCREEN_W-1, posx = SCREEN_W-1 and vx = -vx. Otherwise posx = nx.
    - Y top edge: if ny < 0, posy = 0 and vy = 0 before gravity is applied.
    - Gravity: vy = min(vy + GRAVITY, V_MAX).
    - Exit: if ny >= SCREEN_H and old vy > 0, go to EXIT; posy holds its previous value.
  - EXIT: done = 1 for exactly one cycle, active = 0, then IDLE. launch is ignored in this cycle.
- Slice: slice in FLY sets vx = 0 and sliced_o = 1. slice outside FLY is ignored.
- Slice and update in the same cycle: slice takes effect first, so the update uses vx = 0.
- vy is never negative-saturated. launch_vy below -(2^(V_W-1)) cannot be represented and is outside scope.

Optional Feature:
- Macro: OBJECT_MOTION_WALL_BOUNCE_EN.
- Defined: the x clamp-and-negate rule above applies.
- Undefined:
  - nx outside 0..SCREEN_W-1 ends the flight.
  - State goes to EXIT with posx unchanged, and done pulses.
  - vx is never negated.

Test Plan:
- Reset, then launch x=100, y=470, vx=3, vy=-10, GRAVITY=1.
  - Tick 1 -> posx=103, posy=460, vy_o=-9.
  - Tick 2 -> posx=106, posy=451, vy_o=-8.
  - active=1 throughout.
- In FLY at posy=478, vy=3, apply a tick -> done pulses one cycle, active=0, then back in IDLE; a further tick changes nothing.
- posx=637, vx=5, tick:
  - Bounce enabled -> posx=639, vx becomes -5; next tick posx=634.
  - Bounce disabled -> done pulse, posx stays 637.
- posy=5, vy=-10, tick -> posy=0, vy_o=1. With vy=15 and a tick -> vy_o stays 15 (saturated).
- slice asserted in the same cycle as a tick update, vx=4 -> posx unchanged, sliced_o=1, posy still advances by vy.
- rst asserted mid-flight -> next edge: all outputs 0, IDLE. A tick held high for 10 cycles yields exactly one update. launch during FLY is ignored.
